// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low cathode patterns {CA..CG} and reader FSM encoding.
// The forward hex-to-segment helper uses the same constants so driver and reader agree.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StHeld   = 2'd2
  } scan_state_e;

  // Forward path: nibble to cathode pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] seg;
    case (value)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_pattern_to_hex.sv
// Combinational reverse decoder: cathode pattern to nibble with blank/legal flags.
// Blank counts as legal and decodes to nibble 0.
module seg7_pattern_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       is_legal
);

  // Table lookup; anything not in the table is illegal.
  always_comb begin
    nibble   = 4'h0;
    is_blank = 1'b0;
    is_legal = 1'b1;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: is_blank = 1'b1;
      default:   is_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_reader.sv
// Reader for a multiplexed 7-segment bus: samples anode/cathode lines, waits for a pattern to
// stay stable over a settle window, then captures the shown value for the enabled digit.
module seven_seg_scan_reader
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  input  logic                    err_clr,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   blank_out,
  output logic                    frame_done,
  output logic                    pattern_err,
  output logic                    anode_err
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned LC_W  = $clog2(NUM_DIGITS + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

  logic [NUM_DIGITS-1:0]   s_an_q, p_an_q;
  logic [6:0]              s_seg_q, p_seg_q;
  logic [CNT_W-1:0]        cnt_q;
  scan_state_e             state_q, state_d;
  logic                    capture;
  logic                    sample_change;
  logic [LC_W-1:0]         low_count;
  logic [IDX_W-1:0]        low_idx;
  logic                    one_low, multi_low;
  logic [3:0]              dec_nibble;
  logic                    dec_blank, dec_legal;
  logic [NUM_DIGITS-1:0]   mask_q, mask_set;
  logic [4*NUM_DIGITS-1:0] digits_q;
  logic [NUM_DIGITS-1:0]   valid_q, blank_q;
  logic                    frame_done_q, pattern_err_q, anode_err_q;

  // Sample register plus the previous sample, so change detection compares two registered values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_an_q  <= '1;
      s_seg_q <= '1;
      p_an_q  <= '1;
      p_seg_q <= '1;
    end else begin
      s_an_q  <= an_in;
      s_seg_q <= seg_in;
      p_an_q  <= s_an_q;
      p_seg_q <= s_seg_q;
    end
  end

  assign sample_change = (s_an_q != p_an_q) || (s_seg_q != p_seg_q);

  // Count low anodes and remember which one is low.
  always_comb begin
    low_count = '0;
    low_idx   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_an_q[i]) begin
        low_count = low_count + LC_W'(1);
        low_idx   = IDX_W'(i);
      end
    end
  end

  assign one_low   = (low_count == LC_W'(1));
  assign multi_low = (low_count > LC_W'(1));

  seg7_pattern_to_hex u_decode (
    .pattern  (s_seg_q),
    .nibble   (dec_nibble),
    .is_blank (dec_blank),
    .is_legal (dec_legal)
  );

  // Settle counter: restarts on any sample change, saturates otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (sample_change) begin
      cnt_q <= '0;
    end else if (cnt_q != CntMax) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a change on the capture cycle wins so the window must be fully stable.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (!one_low) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   state_d = StSettle;
        StSettle: begin
          if (!sample_change && (cnt_q == CntLast)) begin
            state_d = StHeld;
            capture = 1'b1;
          end
        end
        StHeld:   if (sample_change) state_d = StSettle;
        default:  state_d = StIdle;
      endcase
    end
  end

  assign mask_set = mask_q | (NUM_DIGITS'(1) << low_idx);

  // Capture registers, frame mask and frame pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q     <= '0;
      valid_q      <= '0;
      blank_q      <= '0;
      mask_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (capture) begin
        if (&mask_set) begin
          mask_q       <= '0;
          frame_done_q <= 1'b1;
        end else begin
          mask_q <= mask_set;
        end
        if (dec_legal) begin
          digits_q[4*low_idx +: 4] <= dec_nibble;
          valid_q[low_idx]         <= 1'b1;
          blank_q[low_idx]         <= dec_blank;
        end else begin
          valid_q[low_idx] <= 1'b0;
          blank_q[low_idx] <= 1'b0;
        end
      end
    end
  end

  // Sticky error flags; a set in the same cycle as err_clr wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_err_q <= 1'b0;
      anode_err_q   <= 1'b0;
    end else begin
      if (capture && !dec_legal) pattern_err_q <= 1'b1;
      else if (err_clr)          pattern_err_q <= 1'b0;
      if (multi_low)             anode_err_q   <= 1'b1;
      else if (err_clr)          anode_err_q   <= 1'b0;
    end
  end

  assign digits_out  = digits_q;
  assign digit_valid = valid_q;
  assign blank_out   = blank_q;
  assign frame_done  = frame_done_q;
  assign pattern_err = pattern_err_q;
  assign anode_err   = anode_err_q;

endmodule
